// File: rtl/enc_b_accumulator.sv
// enc_b_accumulator: accumulates b = A*s + e mod 2^W from a beat stream, then
// drains the finished b vector in index order over a ready/valid port.
module enc_b_accumulator #(
  parameter int unsigned N = 50,
  parameter int unsigned W = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic         beat_valid_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] e_in,
  input  logic [9:0]   b_idx_in,
  input  logic         e_zero_in,
  input  logic         last_in,
  output logic [W-1:0] b_out,
  output logic [9:0]   b_idx_out,
  output logic         b_valid_out,
  input  logic         b_ready_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  acc_q [N];
  logic          acc_clr_c;
  logic [W-1:0]  acc_sum_c;
  logic          idx_ok_c;
  logic [IW-1:0] ptr_inc_c;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;
  logic [IW-1:0] s1_idx_q, s1_idx_d;
  logic [W-1:0]  s1_p_q, s1_p_d;
  logic [W-1:0]  s1_e_q, s1_e_d;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  b_out_q, b_out_d;
  logic [9:0]    b_idx_q, b_idx_d;
  logic          b_valid_q, b_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  assign idx_ok_c  = (32'(b_idx_in) < N);
  assign ptr_inc_c = ptr_q + IW'(1);
  // Stage-2 read-modify-write value; wraps mod 2^W.
  assign acc_sum_c = acc_q[s1_idx_q] + s1_p_q + s1_e_q;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, stage-1 capture and drain output next values.
  always_comb begin
    state_d    = state_q;
    acc_clr_c  = 1'b0;
    s1_valid_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_p_d     = s1_p_q;
    s1_e_d     = s1_e_q;
    ptr_d      = ptr_q;
    b_out_d    = b_out_q;
    b_idx_d    = b_idx_q;
    b_valid_d  = b_valid_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_ACCUM: begin
        if (beat_valid_in) begin
          if (idx_ok_c) begin
            s1_valid_d = 1'b1;
            s1_idx_d   = IW'(b_idx_in);
            s1_p_d     = W'(PW'(a_in) * PW'(s_in));
            s1_e_d     = e_zero_in ? '0 : e_in;
          end else begin
            err_d = 1'b1;
          end
          if (last_in) begin
            s1_last_d = 1'b1;
            state_d   = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The last beat stays tracked in stage 1 even when its index was dropped,
        // so the flush length does not depend on the beat being in range.
        if (!s1_valid_q && !s1_last_q) begin
          state_d   = S_DRAIN;
          ptr_d     = '0;
          b_out_d   = acc_q[0];
          b_idx_d   = '0;
          b_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (b_ready_in) begin
          if (ptr_q == IW'(N - 1)) begin
            state_d   = S_DONE;
            b_valid_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            ptr_d   = ptr_inc_c;
            b_out_d = acc_q[ptr_inc_c];
            b_idx_d = 10'(ptr_inc_c);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // start restarts from any state and drops a beat presented alongside it.
    if (start_in) begin
      state_d    = S_ACCUM;
      acc_clr_c  = 1'b1;
      err_d      = 1'b0;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      b_valid_d  = 1'b0;
      done_d     = 1'b0;
      ptr_d      = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Pipeline and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_p_q     <= '0;
      s1_e_q     <= '0;
      ptr_q      <= '0;
      b_out_q    <= '0;
      b_idx_q    <= '0;
      b_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_idx_q   <= s1_idx_d;
      s1_p_q     <= s1_p_d;
      s1_e_q     <= s1_e_d;
      ptr_q      <= ptr_d;
      b_out_q    <= b_out_d;
      b_idx_q    <= b_idx_d;
      b_valid_q  <= b_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Accumulator array: clear on reset/start, otherwise stage-2 write.
  always_ff @(posedge clk_in) begin
    if (rst_in || acc_clr_c) begin
      for (int unsigned i = 0; i < N; i++) acc_q[IW'(i)] <= '0;
    end else if (s1_valid_q) begin
      acc_q[s1_idx_q] <= acc_sum_c;
    end
  end

  assign b_out       = b_out_q;
  assign b_idx_out   = b_idx_q;
  assign b_valid_out = b_valid_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_enc_b_accumulator.sv
// Bench for enc_b_accumulator: directed cases plus randomized encryptions
// checked against an arithmetic model of b = A*s + e mod 2^W.
module tb_enc_b_accumulator;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = $clog2(N);
  localparam longint unsigned MOD = 64'd1 << W;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         start_in = 1'b0;
  logic         beat_valid_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] s_in = '0;
  logic [W-1:0] e_in = '0;
  logic [9:0]   b_idx_in = '0;
  logic         e_zero_in = 1'b0;
  logic         last_in = 1'b0;
  logic [W-1:0] b_out;
  logic [9:0]   b_idx_out;
  logic         b_valid_out;
  logic         b_ready_in = 1'b0;
  logic         busy_out;
  logic         done_out;
  logic         err_out;

  enc_b_accumulator #(.N(N), .W(W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .beat_valid_in (beat_valid_in),
    .a_in          (a_in),
    .s_in          (s_in),
    .e_in          (e_in),
    .b_idx_in      (b_idx_in),
    .e_zero_in     (e_zero_in),
    .last_in       (last_in),
    .b_out         (b_out),
    .b_idx_out     (b_idx_out),
    .b_valid_out   (b_valid_out),
    .b_ready_in    (b_ready_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out)
  );

  always #5 clk_in = ~clk_in;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_on    = 1'b0;

  // Reference model state.
  logic [W-1:0] model_b [N];
  bit           model_err = 1'b0;

  // Drain tracking and captured DUT drain values.
  int           exp_ptr  = 0;
  logic         done_exp = 1'b0;
  logic [W-1:0] cap_b [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(N); i++) model_b[IW'(i)] = '0;
    model_err = 1'b0;
  endtask

  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] s,
                            input logic [W-1:0] e, input int idx, input bit ez);
    longint unsigned prod;
    longint unsigned sum;
    if (idx >= int'(N)) begin
      model_err = 1'b1;
      return;
    end
    prod = (64'(a) * 64'(s)) % MOD;
    sum  = 64'(model_b[IW'(idx)]) + prod + (ez ? 64'd0 : 64'(e));
    model_b[IW'(idx)] = W'(sum % MOD);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Pulse start; with_beat presents a beat that must be dropped.
  task automatic do_start(input bit with_beat);
    start_in      = 1'b1;
    beat_valid_in = with_beat;
    a_in          = 16'd5;
    s_in          = 16'd5;
    e_in          = 16'd5;
    b_idx_in      = 10'd0;
    e_zero_in     = 1'b0;
    last_in       = 1'b0;
    model_clear();
    tick();
    start_in      = 1'b0;
    beat_valid_in = 1'b0;
    check("busy_after_start", 32'(busy_out), 1);
    check("err_after_start", 32'(err_out), 0);
    check("valid_after_start", 32'(b_valid_out), 0);
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] e,
                      input int idx, input bit ez, input bit last);
    beat_valid_in = 1'b1;
    a_in      = a;
    s_in      = s;
    e_in      = e;
    b_idx_in  = 10'(idx);
    e_zero_in = ez;
    last_in   = last;
    model_beat(a, s, e, idx, ez);
    tick();
    beat_valid_in = 1'b0;
    last_in       = 1'b0;
  endtask

  // Beat arriving after the last one; must be ignored.
  task automatic junk_beat();
    beat_valid_in = 1'b1;
    a_in      = W'($urandom);
    s_in      = W'($urandom);
    e_in      = W'($urandom);
    b_idx_in  = 10'($urandom_range(0, N - 1));
    e_zero_in = 1'b0;
    last_in   = 1'($urandom_range(0, 1));
    tick();
    beat_valid_in = 1'b0;
    last_in       = 1'b0;
  endtask

  task automatic drain(input int stall_at, input int stall_len, input bit rnd);
    int cyc     = 0;
    int stalled = 0;
    bit seen    = 1'b0;
    while (!seen && cyc < 200) begin
      if (b_valid_out && int'(b_idx_out) == stall_at && stalled < stall_len) begin
        b_ready_in = 1'b0;
        stalled++;
      end else begin
        b_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      cyc++;
      if (done_out) seen = 1'b1;
    end
    b_ready_in = 1'b0;
    check("done_within_budget", 32'(seen), 1);
  endtask

  // Called right after the last beat's edge: checks flush latency, then drains.
  task automatic tail_and_drain(input int stall_at, input int stall_len, input bit rnd);
    check("flush_t1_valid", 32'(b_valid_out), 0);
    check("flush_t1_busy", 32'(busy_out), 1);
    junk_beat();
    check("flush_t2_valid", 32'(b_valid_out), 0);
    junk_beat();
    check("drain_t3_valid", 32'(b_valid_out), 1);
    check("err_out", 32'(err_out), 32'(model_err));
    drain(stall_at, stall_len, rnd);
    tick();
    check("busy_after_done", 32'(busy_out), 0);
    check("done_pulse_end", 32'(done_out), 0);
  endtask

  // Drain pointer and done expectation derived from observed handshakes.
  always @(posedge clk_in) begin
    if (start_in) exp_ptr <= 0;
    else if (b_valid_out && b_ready_in) exp_ptr <= exp_ptr + 1;
    done_exp <= !start_in && b_valid_out && b_ready_in && (exp_ptr == int'(N) - 1);
    if (b_valid_out && b_ready_in && exp_ptr < int'(N)) cap_b[IW'(exp_ptr)] <= b_out;
  end

  // Per-cycle compare of drain outputs against the model.
  initial begin : cmp
    forever begin
      @(negedge clk_in);
      if (chk_on) begin
        check("done_out", 32'(done_out), 32'(done_exp));
        if (b_valid_out) begin
          check("b_idx_out", 32'(b_idx_out), 32'(exp_ptr));
          if (exp_ptr < int'(N))
            check("b_out", 32'(b_out), 32'(model_b[IW'(exp_ptr)]));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nb;
    int idx;
    model_clear();
    for (int i = 0; i < int'(N); i++) cap_b[IW'(i)] = '0;

    // Reset state.
    rst_in = 1'b1;
    repeat (3) tick();
    check("rst_b_out", 32'(b_out), 0);
    check("rst_b_idx_out", 32'(b_idx_out), 0);
    check("rst_b_valid", 32'(b_valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_done", 32'(done_out), 0);
    check("rst_err", 32'(err_out), 0);
    rst_in = 1'b0;
    tick();
    chk_on = 1'b1;

    // Beats in IDLE are ignored.
    beat_valid_in = 1'b1; b_idx_in = 10'd1; a_in = 16'd9; s_in = 16'd9;
    tick();
    beat_valid_in = 1'b0;
    check("idle_busy", 32'(busy_out), 0);

    // Single contribution.
    do_start(1'b0);
    beat(16'd3, 16'd5, 16'd7, 2, 1'b0, 1'b1);
    tail_and_drain(-1, 0, 1'b0);
    check("single_b0", 32'(cap_b[0]), 0);
    check("single_b1", 32'(cap_b[1]), 0);
    check("single_b2", 32'(cap_b[2]), 22);
    check("single_b3", 32'(cap_b[3]), 0);

    // Back-to-back same index.
    do_start(1'b0);
    beat(16'd2, 16'd3, 16'd9, 1, 1'b1, 1'b0);
    beat(16'd4, 16'd5, 16'd9, 1, 1'b1, 1'b1);
    tail_and_drain(-1, 0, 1'b0);
    check("b2b_b1", 32'(cap_b[1]), 26);

    // Wrap-around.
    do_start(1'b0);
    beat(16'hFFFF, 16'hFFFF, 16'd0, 0, 1'b0, 1'b0);
    beat(16'hFFFF, 16'd1, 16'd1, 0, 1'b0, 1'b1);
    tail_and_drain(-1, 0, 1'b0);
    check("wrap_b0", 32'(cap_b[0]), 1);

    // Out-of-range index.
    do_start(1'b0);
    beat(16'd1, 16'd2, 16'd3, 4, 1'b0, 1'b1);
    check("oor_err_set", 32'(err_out), 1);
    tail_and_drain(-1, 0, 1'b0);
    for (int i = 0; i < int'(N); i++) check("oor_zero", 32'(cap_b[IW'(i)]), 0);
    check("oor_err_sticky", 32'(err_out), 1);

    // Drain backpressure at ptr 1 (do_start checks err cleared).
    do_start(1'b0);
    beat(16'd10, 16'd11, 16'd1, 0, 1'b0, 1'b0);
    beat(16'd12, 16'd13, 16'd2, 1, 1'b0, 1'b0);
    beat(16'd5, 16'd6, 16'd0, 3, 1'b1, 1'b1);
    tail_and_drain(1, 5, 1'b0);
    check("bp_b0", 32'(cap_b[0]), 111);
    check("bp_b1", 32'(cap_b[1]), 158);
    check("bp_b3", 32'(cap_b[3]), 30);

    // Abort mid-ACCUM; beat presented with start is dropped.
    do_start(1'b0);
    beat(16'd7, 16'd7, 16'd7, 0, 1'b0, 1'b0);
    beat(16'd8, 16'd8, 16'd8, 1, 1'b0, 1'b0);
    beat(16'd9, 16'd9, 16'd9, 2, 1'b0, 1'b0);
    do_start(1'b1);
    beat(16'd1, 16'd1, 16'd0, 0, 1'b0, 1'b1);
    tail_and_drain(-1, 0, 1'b0);
    check("abort_b0", 32'(cap_b[0]), 1);
    check("abort_b1", 32'(cap_b[1]), 0);
    check("abort_b2", 32'(cap_b[2]), 0);

    // Randomized encryptions with gaps, occasional bad indices and random ready.
    for (int k = 0; k < 20; k++) begin
      do_start(k % 3 == 0);
      nb = $urandom_range(1, 25);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0) tick();
        if ($urandom_range(0, 15) == 0) idx = $urandom_range(N, 1023);
        else                            idx = $urandom_range(0, N - 1);
        beat(W'($urandom), W'($urandom), W'($urandom), idx,
             1'($urandom_range(0, 1)), j == nb - 1);
      end
      tail_and_drain($urandom_range(0, N - 1), $urandom_range(0, 3), 1'b1);
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/enc_b_accumulator.md
# enc_b_accumulator

Accumulates the LWE ciphertext vector b = A·s + e mod 2^W from the operand stream produced by the encryption address looper and its BRAM reads. Each beat carries one A word, one s word, one e word, and the b index they contribute to. Partial sums live in an internal register array. After the last beat, the block drains the finished b vector in index order over a ready/valid port to the ciphertext writer.

## Interface
Parameters:
- N, default 50: length of b (the accumulator entry count).
- W, default 16: word width; all arithmetic is mod 2^W.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse; clears accumulators and begins a new encryption.
- beat_valid_in  input  1  operand beat present this cycle.
- a_in  input  W  A matrix word.
- s_in  input  W  secret word.
- e_in  input  W  error word.
- b_idx_in  input  10  target b index.
- e_zero_in  input  1  1 = do not add e_in for this beat.
- last_in  input  1  marks the final beat of the encryption.
- b_out  output  W  drained b word.
- b_idx_out  output  10  index of b_out.
- b_valid_out  output  1  b_out valid.
- b_ready_in  input  1  consumer accepts b_out.
- busy_out  output  1  high in any state other than IDLE.
- done_out  output  1  one-cycle pulse after the final drain handshake.
- err_out  output  1  sticky flag; set when a beat arrives with b_idx_in ≥ N.

## Operation
States are IDLE, ACCUM, FLUSH, DRAIN, DONE.
- **IDLE**
  - start_in moves to ACCUM.
  - On that same edge all N entries clear to 0 and err_out clears.
  - Beats arriving in IDLE are ignored.
- **ACCUM**
  - A beat is accepted when beat_valid_in=1.
  - Stage 1 registers p = (a_in·s_in)[W-1:0], together with idx, e term (e_in, or 0 when e_zero_in=1), and last.
  - Stage 2 writes acc[idx] <= acc[idx] + p + e_term, truncated to W bits.
  - Stage 2 reads the array combinationally and writes on the same edge, so back-to-back beats to the same index accumulate correctly with no stall.
  - A beat with b_idx_in ≥ N is dropped at stage 1 and sets err_out.
  - An accepted beat with last_in=1 moves to FLUSH.
- **FLUSH**
  - Waits until stage 1 and stage 2 hold no valid data, then moves to DRAIN with the drain pointer at 0.
  - Beats arriving after the last beat are ignored.
- **DRAIN**
  - b_valid_out=1, b_out=acc[ptr], b_idx_out=ptr.
  - ptr increments on each b_valid_out && b_ready_in.
  - The handshake at ptr=N-1 moves to DONE.
  - b_out and b_idx_out stay stable while b_ready_in=0.
- **DONE**
  - done_out=1 for one cycle, then IDLE.
- **start_in in any non-IDLE state**
  - Aborts the current operation.
  - Pipeline valids clear, accumulators clear, err_out clears, state becomes ACCUM.
  - A beat presented in the same cycle as start_in is dropped.
- **Widths**
  - The product is formed at 2W bits and truncated.
  - Sums wrap mod 2^W.
  - b_idx_out is zero-extended from the pointer.

## Timing
- **Reset**
  - State IDLE, all accumulator entries 0.
  - b_out=0, b_idx_out=0, b_valid_out=0, busy_out=0, done_out=0, err_out=0.
  - Pipeline valids 0.
- A beat accepted in cycle t updates its accumulator entry on the rising edge ending cycle t+1.
  - The updated value is readable in cycle t+2.
- Throughput: one beat per cycle; there is no backpressure on the operand side.
- **Last beat to drain**
  - Last beat in cycle t: FLUSH in cycles t+1 and t+2.
  - First b_valid_out in cycle t+3.
- **Drain**
  - N cycles minimum with b_ready_in held at 1.
  - done_out is asserted the cycle after the final handshake.
- busy_out rises the cycle after start_in and falls when DONE is left.

## Test plan
- **Single contribution:** N=4, start; one beat a=3, s=5, e=7, idx=2, e_zero=0, last=1 → drain yields b=[0,0,22,0], then one done_out pulse.
- **Back-to-back same index:** beats idx=1 with (a,s)=(2,3), then (4,5), e_zero=1 both, last on the second → b[1]=26; confirms the single-cycle read-modify-write with no hazard.
- **Wrap-around:** W=16; a=0xFFFF, s=0xFFFF, e=0, idx=0 → product 0xFFFE0001 truncates to 0x0001, so b[0]=1; a second beat with a=0xFFFF, s=1, e=1 → b[0]=0x0001.
- **Out-of-range index:** N=4; beat idx=4 → err_out=1, all b entries 0 on drain; the next start_in clears err_out.
- **Drain backpressure:** hold b_ready_in=0 for 5 cycles at ptr=1 → b_out and b_idx_out are stable, there is no skip or repeat, and done_out occurs only after the handshake at idx N-1.
- **Abort:** start_in asserted mid-ACCUM after 3 beats, then one beat a=1, s=1, e=0, idx=0, last → drain shows only b[0]=1; no stale sums remain.
